// File: rtl/gpio_cfg_sequencer_pkg.sv
// Shared GPIO bus field map and sequencer state encoding for the configuration sequencer.
package ising_config;

  localparam int gpio_bus_width        = 32;
  localparam int gpio_addr_start       = 0;
  localparam int gpio_addr_end         = 15;
  localparam int gpio_data_start       = 16;
  localparam int gpio_data_end         = 23;
  localparam int gpio_w_clk_bit        = 24;
  localparam int gpio_cfg_hold_default = 2;

  typedef enum logic [2:0] {
    st_idle = 3'd0,
    st_load = 3'd1,
    st_high = 3'd2,
    st_low  = 3'd3,
    st_done = 3'd4
  } cfg_state_e;

endpackage

// File: rtl/cfg_phase_timer.sv
// Down-counting phase timer: loaded with a cycle count, pulses expire in the last counted cycle.
module cfg_phase_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] count,
  output logic       expire
);

  logic [7:0] cnt_r;

  // phase counter, reload wins over decrement and it parks at zero
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r <= 8'd0;
    end else if (load) begin
      cnt_r <= count;
    end else if (cnt_r != 8'd0) begin
      cnt_r <= cnt_r - 8'd1;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign expire = (cnt_r == 8'd1);

endmodule

// File: rtl/gpio_cfg_sequencer.sv
// Serialises a multi-byte configuration word onto the GPIO bus, one w_clk strobe per byte.
module gpio_cfg_sequencer
  import ising_config::*;
#(
  parameter int word_width  = 8,
  parameter int num_words   = 4,
  parameter int addr_width  = 16,
  parameter int hold_cycles = gpio_cfg_hold_default
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [num_words*word_width-1:0] s_data,
  input  logic [addr_width-1:0]           s_addr,
  input  logic                            s_valid,
  output logic                            s_ready,
  output logic [31:0]                     gpio_out,
  output logic                            busy,
  output logic                            done
);

  localparam int data_w      = num_words * word_width;
  localparam int cnt_w       = $clog2(num_words + 1);
  localparam int gpio_addr_w = gpio_addr_end - gpio_addr_start + 1;
  localparam int gpio_data_w = gpio_data_end - gpio_data_start + 1;
  localparam logic [7:0]       hold_val = 8'(hold_cycles);
  localparam logic [cnt_w-1:0] last_cnt = cnt_w'(num_words);

  cfg_state_e                state_r;
  cfg_state_e                next_state_s;
  logic [data_w-1:0]         data_r;
  logic [addr_width-1:0]     addr_r;
  logic [cnt_w-1:0]          byte_cnt_r;
  logic [gpio_bus_width-1:0] gpio_out_r;
  logic                      busy_r;
  logic                      done_r;
  logic                      s_ready_r;

  logic                      accept_s;
  logic                      expire_s;
  logic                      timer_load_s;
  logic                      last_byte_s;
  logic [data_w-1:0]         src_data_s;
  logic [addr_width-1:0]     src_addr_s;
  logic [word_width-1:0]     cur_byte_s;
  logic [gpio_addr_w-1:0]    addr_field_s;
  logic [gpio_data_w-1:0]    data_field_s;
  logic [gpio_bus_width-1:0] gpio_next_s;

  assign accept_s     = (state_r == st_idle) && s_valid && s_ready_r;
  assign last_byte_s  = (byte_cnt_r == last_cnt);
  // reload for HIGH while in LOAD, and for LOW in the last HIGH cycle
  assign timer_load_s = (state_r == st_load) || ((state_r == st_high) && expire_s);
  assign cur_byte_s   = src_data_s[data_w-1 -: word_width];

  cfg_phase_timer u_phase_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (timer_load_s),
    .count  (hold_val),
    .expire (expire_s)
  );

  // first byte comes straight from the request port, later bytes from the shift register
  always_comb begin
    if (state_r == st_idle) begin
      src_data_s = s_data;
      src_addr_s = s_addr;
    end else begin
      src_data_s = data_r;
      src_addr_s = addr_r;
    end
  end

  if (addr_width >= gpio_addr_w) begin : g_addr_trunc
    assign addr_field_s = src_addr_s[gpio_addr_w-1:0];
  end else begin : g_addr_pad
    assign addr_field_s = {{(gpio_addr_w - addr_width){1'b0}}, src_addr_s};
  end

  if (word_width >= gpio_data_w) begin : g_data_trunc
    assign data_field_s = cur_byte_s[gpio_data_w-1:0];
  end else begin : g_data_pad
    assign data_field_s = {{(gpio_data_w - word_width){1'b0}}, cur_byte_s};
  end

  // next-state sequencing
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      st_idle: begin
        if (accept_s) next_state_s = st_load;
        else          next_state_s = st_idle;
      end
      st_load: next_state_s = st_high;
      st_high: begin
        if (expire_s) next_state_s = st_low;
        else          next_state_s = st_high;
      end
      st_low: begin
        if (expire_s && last_byte_s)  next_state_s = st_done;
        else if (expire_s)            next_state_s = st_load;
        else                          next_state_s = st_low;
      end
      st_done: next_state_s = st_idle;
      default: next_state_s = st_idle;
    endcase
  end

  // bus image for the coming cycle: fields latch only on entry to LOAD
  always_comb begin
    gpio_next_s = gpio_out_r;
    if (next_state_s == st_load) begin
      gpio_next_s[gpio_addr_end:gpio_addr_start] = addr_field_s;
      gpio_next_s[gpio_data_end:gpio_data_start] = data_field_s;
    end else begin
      gpio_next_s = gpio_out_r;
    end
    gpio_next_s[gpio_w_clk_bit] = (next_state_s == st_high);
    gpio_next_s[gpio_bus_width-1:gpio_w_clk_bit+1] = {(gpio_bus_width-gpio_w_clk_bit-1){1'b0}};
  end

  // state and registered status outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= st_idle;
      gpio_out_r <= {gpio_bus_width{1'b0}};
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      s_ready_r  <= 1'b0;
    end else begin
      state_r    <= next_state_s;
      gpio_out_r <= gpio_next_s;
      busy_r     <= (next_state_s != st_idle);
      done_r     <= (next_state_s == st_done);
      s_ready_r  <= (next_state_s == st_idle);
    end
  end

  // captured request: remaining bytes shift up so the next one is always at the top
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_r <= {data_w{1'b0}};
      addr_r <= {addr_width{1'b0}};
    end else if (next_state_s == st_load) begin
      data_r <= src_data_s << word_width;
      addr_r <= src_addr_s;
    end else begin
      data_r <= data_r;
      addr_r <= addr_r;
    end
  end

  // bytes issued in the current transfer
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      byte_cnt_r <= {cnt_w{1'b0}};
    end else if (next_state_s == st_load) begin
      byte_cnt_r <= byte_cnt_r + cnt_w'(1'b1);
    end else if (state_r == st_done) begin
      byte_cnt_r <= {cnt_w{1'b0}};
    end else begin
      byte_cnt_r <= byte_cnt_r;
    end
  end

  assign gpio_out = gpio_out_r;
  assign busy     = busy_r;
  assign done     = done_r;
  assign s_ready  = s_ready_r;

endmodule
